ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arb_pkg.sv | 19 +
 rtl/ahb_arb_picker.sv | 30 +++
 rtl/ahb_arbiter.sv | 122 ++++++++++++
 tb/tb_ahb_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared types and limits for the AHB bus arbiter
package ahb_arb_pkg;

  localparam int MAX_MASTERS = 16;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    OWN       = 2'd0,
    LOCK      = 2'd1,
    LOCK_TAIL = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ahb_arb_picker.sv
// rtl/ahb_arb_picker.sv - combinational rotate-priority picker (mask + start index -> one-hot winner)
module ahb_arb_picker
  import ahb_arb_pkg::*;
#(
  parameter int N = MAX_MASTERS,
  parameter int W = 4
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] start,
  output logic [N-1:0] winner,
  output logic         valid
);

  logic [W-1:0] idx;

  // Walk the mask from start, wrapping at N; the first set bit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(start) + i) % N);
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB arbiter with lock, SPLIT masking; AHB_ARB_FIXED_PRIO_EN selects fixed priority
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 16,
  parameter int DEFAULT_MASTER = 0,
  localparam int MASTER_W      = ($clog2(NUM_MASTERS) > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hrst,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [NUM_MASTERS-1:0] hsplit,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MASTER_W-1:0]    hmaster,
  output logic                   hmastlock
);

  localparam logic [MASTER_W-1:0]    DEF_IDX    = MASTER_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  function automatic logic [MASTER_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] v);
    logic [MASTER_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (v[i]) r = MASTER_W'(i);
    end
    return r;
  endfunction

  arb_state_e                 state, state_nxt;
  logic [NUM_MASTERS-1:0]     split_mask, split_set;
  logic [NUM_MASTERS-1:0]     eligible, winner, grant_nxt;
  logic [MASTER_W-1:0]        owner, search_start;
  logic                       win_valid, split_hit, rearb;

  assign owner     = onehot_to_idx(hgrant);
  assign split_hit = hready && (hresp == SPLIT) && (hmaster != DEF_IDX);

  // A SPLIT response masks the master that owned the data phase (never the default master).
  always_comb begin
    split_set = '0;
    if (split_hit) split_set[hmaster] = 1'b1;
  end

  // The freshly split master is already excluded from the arbitration on the same edge.
  assign eligible = hbusreq & ~(split_mask | split_set);

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign search_start = '0;
`else
  logic [MASTER_W-1:0] rr_ptr;

  assign search_start = (rr_ptr == MASTER_W'(NUM_MASTERS - 1)) ? '0 : rr_ptr + MASTER_W'(1);

  // Round-robin pointer follows each newly issued grant; frozen while stalled or locked.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      rr_ptr <= DEF_IDX;
    end else if (hready && rearb) begin
      rr_ptr <= onehot_to_idx(grant_nxt);
    end
  end
`endif

  ahb_arb_picker #(
    .N(NUM_MASTERS),
    .W(MASTER_W)
  ) u_picker (
    .eligible(eligible),
    .start   (search_start),
    .winner  (winner),
    .valid   (win_valid)
  );

  // Next grant and lock state; a SPLIT during a locked sequence drops straight back to arbitration.
  always_comb begin
    state_nxt = state;
    grant_nxt = hgrant;
    rearb     = 1'b0;
    if (hready) begin
      case (state)
        OWN:       rearb = 1'b1;
        LOCK: begin
          if (split_hit)                rearb     = 1'b1;
          else if (!(|(hgrant & hlock))) state_nxt = LOCK_TAIL;
        end
        LOCK_TAIL: begin
          if (split_hit) rearb     = 1'b1;
          else           state_nxt = OWN;
        end
        default:   rearb = 1'b1;
      endcase
      if (rearb) begin
        grant_nxt = win_valid ? winner : DEF_ONEHOT;
        state_nxt = (win_valid && |(winner & hlock)) ? LOCK : OWN;
      end
    end
  end

  // Grant/address-phase registers advance only on hready; split mask tracks set/resume every cycle.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state      <= OWN;
      hgrant     <= DEF_ONEHOT;
      hmaster    <= DEF_IDX;
      hmastlock  <= 1'b0;
      split_mask <= '0;
    end else begin
      if (hready) begin
        state     <= state_nxt;
        hgrant    <= grant_nxt;
        hmaster   <= owner;
        hmastlock <= (state == LOCK) || (state == LOCK_TAIL);
      end
      split_mask <= (split_mask & ~hsplit) | split_set;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed self-checking bench for ahb_arbiter (NUM_MASTERS=4)
module tb_ahb_arbiter;

  logic       hclk;
  logic       hrst;
  logic [3:0] hbusreq, hlock, hsplit, hgrant;
  logic       hready;
  logic [1:0] hresp;
  logic [1:0] hmaster;
  logic       hmastlock;

  int checks   = 0;
  int failures = 0;

  int rot_g [4] = '{2, 4, 8, 1};
  int rot_m [4] = '{0, 1, 2, 3};

  ahb_arbiter #(
    .NUM_MASTERS   (4),
    .DEFAULT_MASTER(0)
  ) dut (
    .hclk     (hclk),
    .hrst     (hrst),
    .hbusreq  (hbusreq),
    .hlock    (hlock),
    .hready   (hready),
    .hresp    (hresp),
    .hsplit   (hsplit),
    .hgrant   (hgrant),
    .hmaster  (hmaster),
    .hmastlock(hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hrst    = 1'b1;
    hbusreq = '0;
    hlock   = '0;
    hsplit  = '0;
    hresp   = 2'd0;
    hready  = 1'b1;
    tick();
    hrst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_grant", 32'(hgrant), 1);
    check("rst_master", 32'(hmaster), 0);
    check("rst_mastlock", 32'(hmastlock), 0);
    tick();
    check("idle_default_grant", 32'(hgrant), 1);

`ifdef AHB_ARB_FIXED_PRIO_EN
    hbusreq = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fixed_grant", 32'(hgrant), 2);
    end
`else
    // rotation
    hbusreq = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rot_grant", 32'(hgrant), 32'(rot_g[k]));
      check("rot_master", 32'(hmaster), 32'(rot_m[k]));
    end

    // locked sequence by master 2
    do_reset();
    hbusreq = 4'b0100;
    hlock   = 4'b0100;
    tick();
    check("lock_e1_grant", 32'(hgrant), 4);
    check("lock_e1_mastlock", 32'(hmastlock), 0);
    tick();
    check("lock_e2_master", 32'(hmaster), 2);
    check("lock_e2_mastlock", 32'(hmastlock), 1);
    tick();
    check("lock_e3_mastlock", 32'(hmastlock), 1);
    hlock   = 4'b0000;
    hbusreq = 4'b0001;
    tick();
    check("lock_e4_grant", 32'(hgrant), 4);
    check("lock_e4_mastlock", 32'(hmastlock), 1);
    tick();
    check("tail_grant", 32'(hgrant), 4);
    check("tail_mastlock", 32'(hmastlock), 1);
    tick();
    check("unlock_grant", 32'(hgrant), 1);
    check("unlock_mastlock", 32'(hmastlock), 0);
    check("unlock_master", 32'(hmaster), 2);

    // SPLIT on master 1 with coincident resume: set wins
    do_reset();
    hbusreq = 4'b0010;
    tick();
    tick();
    check("split_pre_master", 32'(hmaster), 1);
    hbusreq = 4'b0011;
    hresp   = 2'd3;
    hsplit  = 4'b0010;
    tick();
    check("split_regrant", 32'(hgrant), 1);
    hresp  = 2'd0;
    hsplit = 4'b0000;
    tick();
    check("split_set_wins", 32'(hgrant), 1);
    check("split_master0", 32'(hmaster), 0);
    hsplit = 4'b0010;
    tick();
    check("resume_old_mask", 32'(hgrant), 1);
    hsplit = 4'b0000;
    tick();
    check("resume_grant", 32'(hgrant), 2);

    // stall
    do_reset();
    hready  = 1'b0;
    hbusreq = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_grant", 32'(hgrant), 1);
      check("stall_master", 32'(hmaster), 0);
    end
    hready = 1'b1;
    tick();
    check("unstall_grant", 32'(hgrant), 2);
    tick();
    check("unstall_grant2", 32'(hgrant), 4);
    check("unstall_master", 32'(hmaster), 1);

    // SPLIT while default master owns the data phase is ignored
    do_reset();
    hbusreq = 4'b0001;
    hlock   = 4'b0001;
    hresp   = 2'd3;
    tick();
    hresp = 2'd0;
    tick();
    check("split_default_ignored", 32'(hmastlock), 1);

    // SPLIT during a locked sequence re-arbitrates at once
    do_reset();
    hbusreq = 4'b0010;
    hlock   = 4'b0010;
    tick();
    tick();
    check("lsplit_mastlock", 32'(hmastlock), 1);
    hresp   = 2'd3;
    hbusreq = 4'b0011;
    tick();
    check("lsplit_grant", 32'(hgrant), 1);
    hresp = 2'd0;
    tick();
    check("lsplit_unlocked", 32'(hmastlock), 0);
    check("lsplit_master", 32'(hmaster), 0);

    // reset in the middle of a lock
    do_reset();
    hbusreq = 4'b0100;
    hlock   = 4'b0100;
    tick();
    tick();
    hrst = 1'b1;
    tick();
    check("rst_lock_grant", 32'(hgrant), 1);
    check("rst_lock_mastlock", 32'(hmastlock), 0);
    check("rst_lock_master", 32'(hmaster), 0);
    hrst    = 1'b0;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    tick();
    check("post_rst_grant", 32'(hgrant), 1);
    check("post_rst_mastlock", 32'(hmastlock), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
